mmio_arbiter: RTL and testbench
===============================

Name: mmio_arbiter

Overview:
- Shares the single mmio load/store port between two requesters: m0 = CPU data port, m1 = DMA/blitter engine (e.g. VRAM fill, UART streaming).
- Sequences every access through an issue/response pipeline, so each slave access is presented for exactly one cycle. Side-effecting reads (kbd, uart FIFO pops) therefore fire exactly once.
- Fixed priority to m0, with a starvation counter that promotes m1.
- Sits between the core/DMA and mmio.

Parameters:
- STARVE_LIMIT, 4, number of consecutive arbitration losses by m1 after which m1 wins the next contested arbitration (range 1..15).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-low reset
- m0_req  input  1  m0 request; held until m0_ack
- m0_load  input  1  m0 load
- m0_store  input  1  m0 store
- m0_access  input  3  m0 access type (000 b, 001 h, 010 w, 100 bu, 101 hu)
- m0_addr  input  32  m0 address
- m0_wdata  input  32  m0 store data
- m0_ack  output  1  one-cycle completion pulse
- m0_rdata  output  32  load data, valid while m0_ack=1
- m1_req, m1_load, m1_store, m1_access, m1_addr, m1_wdata, m1_ack, m1_rdata  same as m0 for requester 1
- s_load  output  1  to mmio load
- s_store  output  1  to mmio store
- s_access  output  3  to mmio access
- s_addr  output  32  to mmio addr
- s_data_in  output  32  to mmio data_in
- s_data_out  input  32  from mmio data_out (combinational within the issue cycle)
- grant_id  output  1  master owning the current transaction
- busy  output  1  1 when not in IDLE

Behaviour:
- Clock and reset: single clock clk; rst is synchronous, active-low. Sampled at posedge clk, rst=0 forces reset state.
- Reset values: state=IDLE, starve_cnt=0. All outputs 0: acks, rdata, s_* signals, grant_id, busy.
- Reset mid-transaction: the in-flight transaction is dropped with no ack; the slave sees no further access.
- FSM states:
  - IDLE: arbitrate. If any req, latch the winner's load/store/access/addr/wdata and grant_id, then go to ISSUE.
  - ISSUE: s_* driven from the latched registers for exactly one cycle. s_data_out is captured into the winner's rdata register at the clock edge. Next state RESP.
  - RESP: the winner's ack=1 for one cycle, rdata valid. Next state IDLE.
- Outside ISSUE: s_load=s_store=0, s_access=0, s_addr=0, s_data_in=0. No spurious slave access ever.
- Latency: req seen in IDLE at edge N; ISSUE during cycle N+1; ack during cycle N+2. Minimum spacing between transactions is 3 cycles.
- Requester protocol: deassert req (or present a new request) in the ack cycle. Req is ignored during ISSUE and RESP and re-sampled in IDLE.
- Arbitration:
  - Only one req active: that master wins.
  - Both active, starve_cnt < STARVE_LIMIT: m0 wins and starve_cnt increments.
  - Both active, starve_cnt == STARVE_LIMIT: m1 wins.
  - starve_cnt clears to 0 whenever m1 is granted or m1_req=0 in IDLE.
  - starve_cnt saturates at STARVE_LIMIT.
- Request normalisation, applied at latch time:
  - load and store both 1: treated as store (load forced 0).
  - req with neither load nor store: null transaction; the FSM still runs, s_load=s_store=0 in ISSUE, ack with rdata=0.
- rdata of a store transaction is 0. The losing master's ack and rdata stay 0.
- rdata holds its value after ack until that master's next ack; only the ack cycle is meaningful.

Decomposition:
- Shared package mmio_pkg:
  - access encodings (ACC_B, ACC_H, ACC_W, ACC_BU, ACC_HU)
  - FSM state enum (ARB_IDLE, ARB_ISSUE, ARB_RESP)
  - MMIO address constants (KBD_DATA 0xfbadbeef, UART_RDATA 0xfbada002, etc.) for benches
- No sub-module; the arbitration/starvation logic is small enough to stay inline.

Test Plan:
- rst=0 for 2 cycles with both req=1: all outputs 0, no s_load or s_store pulses. Release reset: m0 is granted first.
- m0 lbu at 0xfbadbeef with s_data_out=0x41 in ISSUE: s_load=1 for exactly 1 cycle at N+1; m0_ack at N+2 with m0_rdata=0x41.
- m0 and m1 both requesting continuously (each re-raising req after ack), STARVE_LIMIT=4: grant sequence m0,m0,m0,m0,m1,m0,m0,m0,m0,m1.
- m1 sb to 0xfbada003, wdata 0x5A: s_store=1, s_access=000, s_data_in=0x5A for 1 cycle; m1_ack with m1_rdata=0; m0_ack stays 0.
- Request with load=store=1 (sw 0xfbadc0fe): s_store=1, s_load=0. Request with neither set: no s_* activity, ack with rdata=0 after 2 cycles.
- rst=0 asserted during ISSUE: no ack issued, FSM in IDLE next cycle, starve_cnt=0.

Source files
------------

// File: rtl/mmio_pkg.sv
// ============================================================================
// Module      : mmio_pkg
// Description : Shared access encodings, arbiter FSM states and MMIO addresses.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mmio_pkg;

    localparam logic [2:0] ACC_B  = 3'b000;
    localparam logic [2:0] ACC_H  = 3'b001;
    localparam logic [2:0] ACC_W  = 3'b010;
    localparam logic [2:0] ACC_BU = 3'b100;
    localparam logic [2:0] ACC_HU = 3'b101;

    localparam logic [31:0] KBD_DATA   = 32'hfbad_beef;
    localparam logic [31:0] UART_RDATA = 32'hfbad_a002;
    localparam logic [31:0] UART_WDATA = 32'hfbad_a003;
    localparam logic [31:0] LED_DATA   = 32'hfbad_c0fe;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_RESP  = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic        load;
        logic        store;
        logic [2:0]  access;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mmio_req_t;

    // A request asserting both load and store is performed as a store.
    function automatic mmio_req_t normalise_req(
        input logic        load,
        input logic        store,
        input logic [2:0]  access,
        input logic [31:0] addr,
        input logic [31:0] wdata
    );
        mmio_req_t r;
        r.load   = load & ~store;
        r.store  = store;
        r.access = access;
        r.addr   = addr;
        r.wdata  = wdata;
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mmio_arbiter_if.sv
// ============================================================================
// Module      : mmio_arbiter_if
// Description : Requester, slave-bus and status signals of the MMIO arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mmio_arbiter_if;

    logic        m0_req;
    logic        m0_load;
    logic        m0_store;
    logic [2:0]  m0_access;
    logic [31:0] m0_addr;
    logic [31:0] m0_wdata;
    logic        m0_ack;
    logic [31:0] m0_rdata;

    logic        m1_req;
    logic        m1_load;
    logic        m1_store;
    logic [2:0]  m1_access;
    logic [31:0] m1_addr;
    logic [31:0] m1_wdata;
    logic        m1_ack;
    logic [31:0] m1_rdata;

    logic        s_load;
    logic        s_store;
    logic [2:0]  s_access;
    logic [31:0] s_addr;
    logic [31:0] s_data_in;
    logic [31:0] s_data_out;

    logic        grant_id;
    logic        busy;

    // Arbiter side
    modport slave (
        input  m0_req, m0_load, m0_store, m0_access, m0_addr, m0_wdata,
        input  m1_req, m1_load, m1_store, m1_access, m1_addr, m1_wdata,
        input  s_data_out,
        output m0_ack, m0_rdata, m1_ack, m1_rdata,
        output s_load, s_store, s_access, s_addr, s_data_in,
        output grant_id, busy
    );

    // Requesters plus the MMIO block
    modport master (
        output m0_req, m0_load, m0_store, m0_access, m0_addr, m0_wdata,
        output m1_req, m1_load, m1_store, m1_access, m1_addr, m1_wdata,
        output s_data_out,
        input  m0_ack, m0_rdata, m1_ack, m1_rdata,
        input  s_load, s_store, s_access, s_addr, s_data_in,
        input  grant_id, busy
    );

endinterface

`default_nettype wire

// File: rtl/mmio_arbiter.sv
// ============================================================================
// Module      : mmio_arbiter
// Description : Two-master MMIO arbiter, fixed m0 priority with m1 starvation
//               promotion; every slave access lasts exactly one cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mmio_arbiter
    import mmio_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input wire            clk,
    input wire            rst,
    mmio_arbiter_if.slave bus
);

    localparam logic [3:0] C_STARVE_LIMIT = 4'(STARVE_LIMIT);

    arb_state_t  r_state;
    arb_state_t  w_state_next;
    mmio_req_t   r_req;
    mmio_req_t   w_req_sel;
    logic        r_grant;
    logic        w_m1_win;
    logic        w_any_req;
    logic [3:0]  r_starve_cnt;
    logic [3:0]  w_starve_next;
    logic [31:0] r_rdata0;
    logic [31:0] r_rdata1;
    logic        w_issue;
    logic        w_slave_active;

    assign w_any_req = bus.m0_req | bus.m1_req;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_m1_win      = 1'b0;
        w_starve_next = r_starve_cnt;
        case (r_state)
            ARB_IDLE: begin
                if (bus.m0_req && bus.m1_req) begin
                    if (r_starve_cnt >= C_STARVE_LIMIT) begin
                        w_m1_win      = 1'b1;
                        w_starve_next = 4'd0;
                    end else begin
                        w_starve_next = r_starve_cnt + 4'd1;
                    end
                end else if (bus.m1_req) begin
                    w_m1_win      = 1'b1;
                    w_starve_next = 4'd0;
                end else begin
                    // m1 not waiting, so it cannot be starving
                    w_starve_next = 4'd0;
                end
                if (w_any_req) begin
                    w_state_next = ARB_ISSUE;
                end
            end
            ARB_ISSUE: w_state_next = ARB_RESP;
            ARB_RESP:  w_state_next = ARB_IDLE;
            default:   w_state_next = ARB_IDLE;
        endcase
    end

    assign w_req_sel = w_m1_win
        ? normalise_req(bus.m1_load, bus.m1_store, bus.m1_access, bus.m1_addr, bus.m1_wdata)
        : normalise_req(bus.m0_load, bus.m0_store, bus.m0_access, bus.m0_addr, bus.m0_wdata);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_starve_cnt <= 4'd0;
            r_grant      <= 1'b0;
            r_req        <= '0;
            r_rdata0     <= 32'd0;
            r_rdata1     <= 32'd0;
        end else begin
            if (r_state == ARB_IDLE) begin
                r_starve_cnt <= w_starve_next;
                if (w_any_req) begin
                    r_req   <= w_req_sel;
                    r_grant <= w_m1_win;
                end
            end
            if (r_state == ARB_ISSUE) begin
                if (r_grant) begin
                    r_rdata1 <= r_req.load ? bus.s_data_out : 32'd0;
                end else begin
                    r_rdata0 <= r_req.load ? bus.s_data_out : 32'd0;
                end
            end
        end
    end

    // Null transactions keep the whole slave bus quiet, not just the strobes.
    assign w_issue        = (r_state == ARB_ISSUE);
    assign w_slave_active = w_issue & (r_req.load | r_req.store);

    assign bus.s_load    = w_issue & r_req.load;
    assign bus.s_store   = w_issue & r_req.store;
    assign bus.s_access  = w_slave_active ? r_req.access : 3'd0;
    assign bus.s_addr    = w_slave_active ? r_req.addr   : 32'd0;
    assign bus.s_data_in = w_slave_active ? r_req.wdata  : 32'd0;

    assign bus.m0_ack   = (r_state == ARB_RESP) & ~r_grant;
    assign bus.m1_ack   = (r_state == ARB_RESP) &  r_grant;
    assign bus.m0_rdata = r_rdata0;
    assign bus.m1_rdata = r_rdata1;
    assign bus.grant_id = r_grant;
    assign bus.busy     = (r_state != ARB_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_mmio_arbiter.sv
// ============================================================================
// Module      : tb_mmio_arbiter
// Description : Vector table plus scoreboard bench for mmio_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_mmio_arbiter;
    import mmio_pkg::*;

    localparam int STARVE_LIMIT = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mmio_arbiter_if bus();

    mmio_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int tb_sc   = 0;

    typedef struct packed {
        logic        master;
        logic        load;
        logic        store;
        logic [2:0]  acc;
        logic [31:0] addr;
        logic [31:0] wdata;
    } vec_t;

    typedef struct {
        logic        grant;
        logic        sload;
        logic        sstore;
        logic [2:0]  acc;
        logic [31:0] addr;
        logic [31:0] din;
        logic [31:0] rdata;
        int          active;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[8];

    function automatic logic [31:0] slave_model(input logic [31:0] a);
        return (a == KBD_DATA) ? 32'h0000_0041 : (a ^ 32'hA5A5_0F0F);
    endfunction

    always_comb bus.s_data_out = slave_model(bus.s_addr);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic exp_t make_exp(input vec_t v);
        exp_t e;
        logic ld;
        ld       = v.load & ~v.store;
        e.grant  = v.master;
        e.sload  = ld;
        e.sstore = v.store;
        e.active = (ld | v.store) ? 1 : 0;
        e.acc    = (ld | v.store) ? v.acc  : 3'd0;
        e.addr   = (ld | v.store) ? v.addr : 32'd0;
        e.din    = v.wdata;
        e.rdata  = ld ? slave_model(v.addr) : 32'd0;
        return e;
    endfunction

    // Monitor: snapshot the ISSUE cycle, score it when the ack arrives.
    initial begin
        logic        prev_busy;
        int          active_cyc;
        logic        i_load, i_store, i_grant;
        logic [2:0]  i_acc;
        logic [31:0] i_addr, i_din;
        exp_t        e;
        prev_busy = 1'b0;
        active_cyc = 0;
        {i_load, i_store, i_grant, i_acc, i_addr, i_din} = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                active_cyc = 0;
                prev_busy  = 1'b0;
            end else begin
                if (bus.s_load || bus.s_store) active_cyc++;
                if (bus.busy && !prev_busy) begin
                    i_load  = bus.s_load;
                    i_store = bus.s_store;
                    i_grant = bus.grant_id;
                    i_acc   = bus.s_access;
                    i_addr  = bus.s_addr;
                    i_din   = bus.s_data_in;
                end
                prev_busy = bus.busy;
                if (bus.m0_ack || bus.m1_ack) begin
                    if (sb.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_ack: got m0_ack=%b m1_ack=%b required none", bus.m0_ack, bus.m1_ack);
                    end else begin
                        e = sb.pop_front();
                        check("ack_pair", {30'd0, bus.m1_ack, bus.m0_ack}, e.grant ? 32'd2 : 32'd1);
                        check("grant_id", {31'd0, i_grant}, {31'd0, e.grant});
                        check("s_load", {31'd0, i_load}, {31'd0, e.sload});
                        check("s_store", {31'd0, i_store}, {31'd0, e.sstore});
                        check("s_access", {29'd0, i_acc}, {29'd0, e.acc});
                        check("s_addr", i_addr, e.addr);
                        if (e.sstore) check("s_data_in", i_din, e.din);
                        check("slave_cycles", 32'(active_cyc), 32'(e.active));
                        check("rdata", e.grant ? bus.m1_rdata : bus.m0_rdata, e.rdata);
                    end
                    active_cyc = 0;
                end
            end
        end
    end

    task automatic drive_m(input logic m, input logic req, input vec_t v);
        if (m) begin
            bus.m1_req = req; bus.m1_load = v.load; bus.m1_store = v.store;
            bus.m1_access = v.acc; bus.m1_addr = v.addr; bus.m1_wdata = v.wdata;
        end else begin
            bus.m0_req = req; bus.m0_load = v.load; bus.m0_store = v.store;
            bus.m0_access = v.acc; bus.m0_addr = v.addr; bus.m0_wdata = v.wdata;
        end
    endtask

    task automatic apply_single(input vec_t v);
        int   cyc;
        logic got;
        sb.push_back(make_exp(v));
        tb_sc = 0;
        @(posedge clk); #1;
        drive_m(v.master, 1'b1, v);
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 10) begin
            @(posedge clk); #1;
            cyc++;
            got = v.master ? bus.m1_ack : bus.m0_ack;
        end
        check("latency", 32'(cyc), 32'd2);
        drive_m(v.master, 1'b0, v);
    endtask

    // Both masters hold loads; grant order comes from a starvation model.
    task automatic run_contested(input int n, output logic [15:0] seq);
        vec_t v0, v1;
        int   acks, cyc;
        logic g;
        v0 = '{master: 1'b0, load: 1'b1, store: 1'b0, acc: ACC_W, addr: 32'h0000_1000, wdata: 32'd0};
        v1 = '{master: 1'b1, load: 1'b1, store: 1'b0, acc: ACC_W, addr: 32'h0000_2000, wdata: 32'd0};
        seq = '0;
        for (int i = 0; i < n; i++) begin
            if (tb_sc == STARVE_LIMIT) begin g = 1'b1; tb_sc = 0; end
            else begin g = 1'b0; tb_sc++; end
            sb.push_back(make_exp(g ? v1 : v0));
        end
        @(posedge clk); #1;
        drive_m(1'b0, 1'b1, v0);
        drive_m(1'b1, 1'b1, v1);
        acks = 0;
        cyc  = 0;
        while (acks < n && cyc < n * 4 + 10) begin
            @(posedge clk); #1;
            cyc++;
            if (bus.m0_ack || bus.m1_ack) begin
                seq[acks] = bus.m1_ack;
                acks++;
            end
        end
        check("contested_acks", 32'(acks), 32'(n));
        drive_m(1'b0, 1'b0, v0);
        drive_m(1'b1, 1'b0, v1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish required finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] seq;
        vec_t        vz;
        vz = '0;

        vecs[0] = '{1'b0, 1'b1, 1'b0, ACC_BU, KBD_DATA,      32'h0000_0000};
        vecs[1] = '{1'b1, 1'b0, 1'b1, ACC_B,  UART_WDATA,    32'h0000_005A};
        vecs[2] = '{1'b0, 1'b1, 1'b1, ACC_W,  LED_DATA,      32'h1234_5678};
        vecs[3] = '{1'b1, 1'b0, 1'b0, ACC_W,  32'h0000_4000, 32'hFFFF_FFFF};
        vecs[4] = '{1'b1, 1'b1, 1'b0, ACC_W,  UART_RDATA,    32'h0000_0000};
        vecs[5] = '{1'b0, 1'b1, 1'b0, ACC_H,  32'h0000_0102, 32'h0000_0000};
        vecs[6] = '{1'b1, 1'b1, 1'b0, ACC_HU, 32'h0000_0206, 32'h0000_0000};
        vecs[7] = '{1'b0, 1'b0, 1'b1, ACC_H,  32'h0000_0300, 32'hCAFE_BABE};

        // Reset held with both masters requesting
        drive_m(1'b0, 1'b1, '{1'b0, 1'b1, 1'b0, ACC_W, 32'h0000_1000, 32'd0});
        drive_m(1'b1, 1'b1, '{1'b1, 1'b1, 1'b0, ACC_W, 32'h0000_2000, 32'd0});
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            check("rst_ctrl", {26'd0, bus.m0_ack, bus.m1_ack, bus.s_load, bus.s_store, bus.grant_id, bus.busy}, 32'd0);
            check("rst_data", bus.m0_rdata | bus.m1_rdata | bus.s_addr | bus.s_data_in | {29'd0, bus.s_access}, 32'd0);
        end
        rst = 1'b1;
        tb_sc = 0;
        run_contested(1, seq);
        check("first_grant_m0", {31'd0, seq[0]}, 32'd0);

        for (int i = 0; i < 8; i++) apply_single(vecs[i]);

        run_contested(10, seq);
        check("starve_seq", {22'd0, seq[9:0]}, 32'h0000_0210);

        // Reset during ISSUE after two m1 losses: counter must restart at 0
        run_contested(2, seq);
        @(posedge clk); #1;
        drive_m(1'b0, 1'b1, '{1'b0, 1'b1, 1'b0, ACC_W, 32'h0000_1000, 32'd0});
        drive_m(1'b1, 1'b1, '{1'b1, 1'b1, 1'b0, ACC_W, 32'h0000_2000, 32'd0});
        @(posedge clk); #1;
        check("mid_issue", {29'd0, bus.busy, bus.s_load, bus.grant_id}, 32'd6);
        rst = 1'b0;
        @(posedge clk); #1;
        check("mid_rst_idle", {28'd0, bus.busy, bus.s_load, bus.m0_ack, bus.m1_ack}, 32'd0);
        rst = 1'b1;
        tb_sc = 0;
        run_contested(5, seq);
        check("post_rst_seq", {27'd0, seq[4:0]}, 32'h0000_0010);

        repeat (4) @(posedge clk);
        drive_m(1'b0, 1'b0, vz);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
